// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Optional statistics counters are enabled by defining IFETCH_STATS_EN.
package ifetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    // One buffered fetch result: address of the following instruction plus the word itself.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc_4;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    // 32-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Entry buffer for the fetch queue: storage, wrapping pointers and occupancy count.
// The head entry is read straight out of registered storage.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  entry_t                 din,
    output entry_t                 dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push_ok_s;
    logic            pop_ok_s;

    // Qualify push/pop against the current occupancy.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (flush) begin
            push_ok_s = 1'b0;
            pop_ok_s  = 1'b0;
        end else begin
            push_ok_s = push && (count_q != FULL_CNT);
            pop_ok_s  = pop && (count_q != {CW{1'b0}});
        end
    end

    // Pointer and occupancy state; a flush empties the buffer and overrides push/pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage, cleared on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {(INSTR_W + ADDR_W){1'b0}};
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == {CW{1'b0}});
    assign count = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues in-order icache reads under a
// credit rule so every response has a free slot, and buffers results for dispatch.
// A redirect flushes buffered entries and discards responses still in flight.
// Defining IFETCH_STATS_EN adds saturating fetched/flushed counters.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_ready,
    input  logic        icache_valid,
    input  logic [31:0] icache_data,
    output logic [31:0] ifetch_pc_4,
    output logic [31:0] ifetch_intruction,
    output logic        ifetch_empty,
    input  logic        Dispatch_ren,
    input  logic        Dispatch_jmp,
    input  logic [31:0] Dispatch_jmp_addr
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_flushed
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH);
    localparam logic [31:0] MAX_L   = 32'(MAX_OUTST);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rpc_q, rpc_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic [OW-1:0]     drop_q, drop_d;

    logic [CW-1:0]     count_s;
    logic [31:0]       used_s;
    logic              issue_s;
    logic              accept_s;
    logic              discard_s;
    logic              push_s;
    logic              pop_s;
    entry_t            din_s;
    entry_t            head_s;
    logic              empty_s;

    // Credit check: buffered plus in-flight never exceeds the buffer depth.
    always_comb begin
        used_s  = 32'(count_s) + 32'(outst_q);
        issue_s = (used_s < DEPTH_L) && (32'(outst_q) < MAX_L) && !Dispatch_jmp;
    end

    // Request is held low while reset is asserted so outputs sit at their reset values.
    assign icache_req  = issue_s && reset;
    assign icache_addr = pc_q;
    assign accept_s    = icache_req && icache_ready;

    // Response routing: stale responses (pending drops, or arriving with a redirect) are discarded.
    always_comb begin
        discard_s = 1'b0;
        push_s    = 1'b0;
        if (icache_valid) begin
            discard_s = (drop_q != {OW{1'b0}}) || Dispatch_jmp;
            push_s    = !discard_s;
        end else begin
            discard_s = 1'b0;
            push_s    = 1'b0;
        end
    end

    // Next-state for fetch PC, response PC and the outstanding/drop counters.
    always_comb begin
        pc_d    = pc_q;
        rpc_d   = rpc_q;
        outst_d = outst_q;
        drop_d  = drop_q;

        case ({accept_s, icache_valid})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        if (Dispatch_jmp) begin
            pc_d   = Dispatch_jmp_addr;
            rpc_d  = Dispatch_jmp_addr;
            // Every request still in flight after this edge belongs to the old stream.
            drop_d = outst_d;
        end else begin
            pc_d   = accept_s ? (pc_q + PC_STEP) : pc_q;
            rpc_d  = push_s ? (rpc_q + PC_STEP) : rpc_q;
            drop_d = (icache_valid && (drop_q != {OW{1'b0}})) ? (drop_q - OW'(1)) : drop_q;
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            rpc_q   <= RESET_PC;
            outst_q <= {OW{1'b0}};
            drop_q  <= {OW{1'b0}};
        end else begin
            pc_q    <= pc_d;
            rpc_q   <= rpc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    assign din_s = '{pc_4: rpc_q + PC_STEP, instr: icache_data};
    assign pop_s = Dispatch_ren && !Dispatch_jmp;

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .flush (Dispatch_jmp),
        .din   (din_s),
        .dout  (head_s),
        .empty (empty_s),
        .count (count_s)
    );

    assign ifetch_pc_4       = head_s.pc_4;
    assign ifetch_intruction = head_s.instr;
    assign ifetch_empty      = empty_s;

`ifdef IFETCH_STATS_EN
    logic [31:0] stat_fetched_q;
    logic [31:0] stat_flushed_q;
    logic [31:0] flush_inc_s;

    // Entries lost this cycle: buffer contents on a redirect plus any discarded response.
    always_comb begin
        flush_inc_s = 32'd0;
        if (Dispatch_jmp) begin
            flush_inc_s = 32'(count_s) + {31'd0, discard_s};
        end else begin
            flush_inc_s = {31'd0, discard_s};
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_fetched_q <= 32'd0;
            stat_flushed_q <= 32'd0;
        end else begin
            stat_fetched_q <= sat_add32(stat_fetched_q, {31'd0, push_s});
            stat_flushed_q <= sat_add32(stat_flushed_q, flush_inc_s);
        end
    end

    assign stat_fetched = stat_fetched_q;
    assign stat_flushed = stat_flushed_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a small in-order icache model.
// Cache returns instr = addr + 32'h20, at the earliest one cycle after acceptance.
module tb_ifetch_queue;

    logic        clock;
    logic        reset;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready;
    logic        icache_valid;
    logic [31:0] icache_data;
    logic [31:0] ifetch_pc_4;
    logic [31:0] ifetch_intruction;
    logic        ifetch_empty;
    logic        Dispatch_ren;
    logic        Dispatch_jmp;
    logic [31:0] Dispatch_jmp_addr;
`ifdef IFETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushed;
`endif

    int          n_checks;
    int          n_errors;
    logic        resp_en;
    logic [31:0] req_q[$];
    logic [31:0] exp_pc4;

    ifetch_queue dut (
        .clock             (clock),
        .reset             (reset),
        .icache_req        (icache_req),
        .icache_addr       (icache_addr),
        .icache_ready      (icache_ready),
        .icache_valid      (icache_valid),
        .icache_data       (icache_data),
        .ifetch_pc_4       (ifetch_pc_4),
        .ifetch_intruction (ifetch_intruction),
        .ifetch_empty      (ifetch_empty),
        .Dispatch_ren      (Dispatch_ren),
        .Dispatch_jmp      (Dispatch_jmp),
        .Dispatch_jmp_addr (Dispatch_jmp_addr)
`ifdef IFETCH_STATS_EN
        ,
        .stat_fetched      (stat_fetched),
        .stat_flushed      (stat_flushed)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: record acceptance, then drive the next in-order response if enabled.
    task automatic tick();
        logic        acc;
        logic        vld;
        logic [31:0] a;
        #1;
        acc = icache_req && icache_ready;
        a   = icache_addr;
        vld = icache_valid;
        @(posedge clock);
        #1;
        if (vld && (req_q.size() > 0)) void'(req_q.pop_front());
        if (acc) req_q.push_back(a);
        if (resp_en && (req_q.size() > 0)) begin
            icache_valid = 1'b1;
            icache_data  = req_q[0] + 32'h20;
        end else begin
            icache_valid = 1'b0;
            icache_data  = 32'h0;
        end
        Dispatch_jmp = 1'b0;
        #1;
    endtask

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        reset             = 1'b0;
        icache_ready      = 1'b1;
        icache_valid      = 1'b0;
        icache_data       = 32'h0;
        Dispatch_ren      = 1'b0;
        Dispatch_jmp      = 1'b0;
        Dispatch_jmp_addr = 32'h0;
        resp_en           = 1'b1;

        // Reset values
        #2;
        chk("rst_req",   {31'd0, icache_req},   32'd0);
        chk("rst_addr",  icache_addr,           32'h0);
        chk("rst_pc4",   ifetch_pc_4,           32'h0);
        chk("rst_instr", ifetch_intruction,     32'h0);
        chk("rst_empty", {31'd0, ifetch_empty}, 32'd1);

        // Test 1: fetch from reset with a 1-cycle cache
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("t1_req0",  {31'd0, icache_req}, 32'd1);
        chk("t1_addr0", icache_addr,         32'h0);
        tick();
        chk("t1_addr1",  icache_addr,           32'h4);
        chk("t1_empty1", {31'd0, ifetch_empty}, 32'd1);
        tick();
        chk("t1_empty2", {31'd0, ifetch_empty}, 32'd0);
        chk("t1_pc4",    ifetch_pc_4,           32'h4);
        chk("t1_instr",  ifetch_intruction,     32'h20);
        chk("t1_addr2",  icache_addr,           32'h8);

        // Test 2: fill with no dispatch, then a single pop grants exactly one request
        repeat (4) tick();
        chk("t2_full_req",   {31'd0, icache_req},   32'd0);
        chk("t2_full_empty", {31'd0, ifetch_empty}, 32'd0);
        chk("t2_full_head",  ifetch_pc_4,           32'h4);
        Dispatch_ren = 1'b1;
        tick();
        Dispatch_ren = 1'b0;
        chk("t2_pop_req",  {31'd0, icache_req}, 32'd1);
        chk("t2_pop_addr", icache_addr,         32'h10);
        chk("t2_pop_head", ifetch_pc_4,         32'h8);
        tick();
        chk("t2_one_req_a", {31'd0, icache_req}, 32'd0);
        tick();
        chk("t2_one_req_b", {31'd0, icache_req}, 32'd0);
        chk("t2_head_keep", ifetch_pc_4,         32'h8);

        // Test 3: streaming, one instruction per cycle
        Dispatch_ren = 1'b1;
        exp_pc4      = 32'hC;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t3_empty", {31'd0, ifetch_empty}, 32'd0);
            chk("t3_pc4",   ifetch_pc_4,           exp_pc4);
            chk("t3_instr", ifetch_intruction,     exp_pc4 + 32'h1C);
            exp_pc4 = exp_pc4 + 32'h4;
        end

        // Test 6: asynchronous reset mid-stream
        reset = 1'b0;
        #1;
        chk("t6_req",   {31'd0, icache_req},   32'd0);
        chk("t6_addr",  icache_addr,           32'h0);
        chk("t6_pc4",   ifetch_pc_4,           32'h0);
        chk("t6_instr", ifetch_intruction,     32'h0);
        chk("t6_empty", {31'd0, ifetch_empty}, 32'd1);
        Dispatch_ren = 1'b0;
        resp_en      = 1'b0;
        req_q.delete();
        icache_valid = 1'b0;
        icache_data  = 32'h0;
        tick();
        chk("t6_hold_empty", {31'd0, ifetch_empty}, 32'd1);
        reset = 1'b1;

        // Test 4: redirect with two requests outstanding
        tick();
        tick();
        chk("t4_maxout_req", {31'd0, icache_req}, 32'd0);
        chk("t4_addr8",      icache_addr,         32'h8);
        Dispatch_jmp      = 1'b1;
        Dispatch_jmp_addr = 32'h100;
        resp_en           = 1'b1;
        #1;
        chk("t4_jmp_req", {31'd0, icache_req}, 32'd0);
        tick();
        chk("t4_flush_empty", {31'd0, ifetch_empty}, 32'd1);
        chk("t4_redir_addr",  icache_addr,           32'h100);
        tick();
        chk("t4_drop1_empty", {31'd0, ifetch_empty}, 32'd1);
        chk("t4_drop1_req",   {31'd0, icache_req},   32'd1);
        tick();
        chk("t4_drop2_empty", {31'd0, ifetch_empty}, 32'd1);
        tick();
        chk("t4_kept_empty", {31'd0, ifetch_empty}, 32'd0);
        chk("t4_kept_pc4",   ifetch_pc_4,           32'h104);
        chk("t4_kept_instr", ifetch_intruction,     32'h120);
`ifdef IFETCH_STATS_EN
        chk("t4_stat_flushed", stat_flushed, 32'd2);
        chk("t4_stat_fetched", stat_fetched, 32'd1);
`endif

        // Test 5: pop+redirect flushes only; pop while empty changes nothing
        icache_ready = 1'b0;
        tick();
        chk("t5_two_head", ifetch_pc_4, 32'h104);
        Dispatch_ren      = 1'b1;
        Dispatch_jmp      = 1'b1;
        Dispatch_jmp_addr = 32'h200;
        tick();
        chk("t5_flush_empty", {31'd0, ifetch_empty}, 32'd1);
        chk("t5_flush_addr",  icache_addr,           32'h200);
        tick();
        chk("t5_idle_empty", {31'd0, ifetch_empty}, 32'd1);
        chk("t5_idle_addr",  icache_addr,           32'h200);
        chk("t5_idle_req",   {31'd0, icache_req},   32'd1);
        Dispatch_ren = 1'b0;
        icache_ready = 1'b1;
        tick();
        tick();
        chk("t5_new_pc4",   ifetch_pc_4,       32'h204);
        chk("t5_new_instr", ifetch_intruction, 32'h220);
        icache_ready = 1'b0;
        Dispatch_ren = 1'b1;
        tick();
        chk("t5_pushpop_empty", {31'd0, ifetch_empty}, 32'd0);
        chk("t5_pushpop_pc4",   ifetch_pc_4,           32'h208);
        Dispatch_ren = 1'b0;
        tick();
        chk("t5_hold_pc4", ifetch_pc_4, 32'h208);
        Dispatch_ren = 1'b1;
        tick();
        chk("t5_drain_empty", {31'd0, ifetch_empty}, 32'd1);
        Dispatch_ren = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
